half_cycle_pipe: RTL and testbench

//   Parametrised mixed-edge register pipeline. Stages alternate posedge/negedge capture
//   on one clock, giving half-cycle latency granularity. Carries WIDTH-bit data with a
//   per-stage valid bit, global hold, flush and a saturating transfer counter.

---
 rtl/half_cycle_pkg.sv | 23 ++
 rtl/half_cycle_pipe_stage.sv | 53 +++++
 rtl/half_cycle_pipe.sv | 111 +++++++++++
 tb/tb_half_cycle_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/half_cycle_pkg.sv
// Shared types and helpers for the mixed-edge half-cycle pipeline.
// HALF_CYCLE_PIPE_PARITY_EN widens every stage by one parity bit.
package half_cycle_pkg;

  typedef enum logic {
    EDGE_POS,
    EDGE_NEG
  } edge_e;

`ifdef HALF_CYCLE_PIPE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  function automatic edge_e stage_edge(
    input int k,
    input bit first
  );
    return ((first ^ k[0]) == 1'b0) ? EDGE_POS : EDGE_NEG;
  endfunction

endpackage

// File: rtl/half_cycle_pipe_stage.sv
// One register stage of the half-cycle pipeline.
// Captures on the clock edge selected by EDGE; rst > flush > en.
module half_cycle_stage
  import half_cycle_pkg::*;
#(
  parameter edge_e EDGE = EDGE_POS,
  parameter int    W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         d_valid,
  input  logic [W-1:0] d,
  output logic         q_valid,
  output logic [W-1:0] q
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (rst) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (flush) begin
      valid_d = 1'b0;
    end else if (en) begin
      valid_d = d_valid;
      data_d  = d;
    end
  end

  if (EDGE == EDGE_POS) begin : g_pos
    always_ff @(posedge clk) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end else begin : g_neg
    always_ff @(negedge clk) begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign q_valid = valid_q;
  assign q       = data_q;

endmodule

// File: rtl/half_cycle_pipe.sv
// Mixed-edge pipeline top: stage chain, transfer counter, parity.
// Optional parity path enabled by HALF_CYCLE_PIPE_PARITY_EN.
module half_cycle_pipe
  import half_cycle_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HALF_STAGES = 2,
  parameter bit FIRST_EDGE  = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
`ifdef HALF_CYCLE_PIPE_PARITY_EN
  input  logic             par_inj,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             par_err
);

  localparam int    DW   = WIDTH + PAR_W;
  localparam int    LAST = HALF_STAGES - 1;
  localparam edge_e LEDG = stage_edge(LAST, FIRST_EDGE);

  // index 0 is the pipe input, index k+1 is stage k
  logic          vld [HALF_STAGES+1];
  logic [DW-1:0] dat [HALF_STAGES+1];

  assign vld[0] = in_valid;
`ifdef HALF_CYCLE_PIPE_PARITY_EN
  assign dat[0] = {par_inj ^ (^in_data), in_data};
`else
  assign dat[0] = in_data;
`endif

  for (genvar g = 0; g < HALF_STAGES; g++) begin : g_stage
    half_cycle_stage #(
      .EDGE (stage_edge(g, FIRST_EDGE)),
      .W    (DW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .flush   (flush),
      .d_valid (vld[g]),
      .d       (dat[g]),
      .q_valid (vld[g+1]),
      .q       (dat[g+1])
    );
  end

  logic             load_last;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign load_last = !rst && !flush && en && vld[LAST];

  always_comb begin
    cnt_d = cnt_q;
    if (rst) begin
      cnt_d = '0;
    end else if (load_last && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef HALF_CYCLE_PIPE_PARITY_EN
  logic perr_q;
  logic perr_d;

  // good words carry even overall parity
  always_comb begin
    perr_d = perr_q;
    if (rst) begin
      perr_d = 1'b0;
    end else if (load_last && (^dat[LAST])) begin
      perr_d = 1'b1;
    end
  end

  assign par_err = perr_q;
`else
  assign par_err = 1'b0;
`endif

  if (LEDG == EDGE_POS) begin : g_cnt_pos
    always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
`ifdef HALF_CYCLE_PIPE_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end else begin : g_cnt_neg
    always_ff @(negedge clk) begin
      cnt_q <= cnt_d;
`ifdef HALF_CYCLE_PIPE_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end

  assign out_valid = vld[HALF_STAGES];
  assign out_data  = dat[HALF_STAGES][WIDTH-1:0];
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_half_cycle_pipe.sv
// Bench for half_cycle_pipe: two configurations, random traffic
// against a half-cycle reference model plus directed scenarios.
module tb_half_cycle_pipe;

  localparam int HS_A = 2;
  localparam int HS_B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       par_inj = 1'b0;

  logic        a_ov;
  logic [7:0]  a_od;
  logic [15:0] a_cnt;
  logic        a_pe;
  logic        b_ov;
  logic [7:0]  b_od;
  logic [3:0]  b_cnt;
  logic        b_pe;

  int n_chk = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  half_cycle_pipe #(
    .WIDTH(8), .HALF_STAGES(HS_A),
    .FIRST_EDGE(1'b0), .CNT_W(16)
  ) u_a (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
`ifdef HALF_CYCLE_PIPE_PARITY_EN
    .par_inj(par_inj),
`endif
    .out_valid(a_ov), .out_data(a_od),
    .xfer_cnt(a_cnt), .par_err(a_pe)
  );

  half_cycle_pipe #(
    .WIDTH(8), .HALF_STAGES(HS_B),
    .FIRST_EDGE(1'b1), .CNT_W(4)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
`ifdef HALF_CYCLE_PIPE_PARITY_EN
    .par_inj(par_inj),
`endif
    .out_valid(b_ov), .out_data(b_od),
    .xfer_cnt(b_cnt), .par_err(b_pe)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: per-stage {valid, parity+data}, u=0 is A, u=1 is B
  bit          mv [2][8];
  logic [8:0]  md [2][8];
  int unsigned mc [2];
  bit          mp [2];

  task automatic model_edge(input bit e);
    for (int u = 0; u < 2; u++) begin
      int n = (u == 0) ? HS_A : HS_B;
      bit fe = (u == 1);
      int unsigned cmax = (u == 0) ? 65535 : 15;
      for (int k = n - 1; k >= 0; k--) begin
        bit sv;
        logic [8:0] sd;
        bit se = fe ^ k[0];
        if (se != e) continue;
        if (k == 0) begin
          sv = in_valid;
          sd = {1'b0, in_data};
`ifdef HALF_CYCLE_PIPE_PARITY_EN
          sd[8] = (^in_data) ^ par_inj;
`endif
        end else begin
          sv = mv[u][k-1];
          sd = md[u][k-1];
        end
        if (rst) begin
          mv[u][k] = 1'b0;
          md[u][k] = '0;
          if (k == n - 1) begin
            mc[u] = 0;
            mp[u] = 1'b0;
          end
        end else if (flush) begin
          mv[u][k] = 1'b0;
        end else if (en) begin
          mv[u][k] = sv;
          md[u][k] = sd;
          if (k == n - 1 && sv) begin
            if (mc[u] < cmax) mc[u]++;
`ifdef HALF_CYCLE_PIPE_PARITY_EN
            if (^sd) mp[u] = 1'b1;
`endif
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string ed);
    chk({"a_valid_", ed}, a_ov, mv[0][HS_A-1]);
    chk({"a_data_", ed}, a_od, md[0][HS_A-1][7:0]);
    chk({"a_cnt_", ed}, a_cnt, mc[0]);
    chk({"a_perr_", ed}, a_pe, mp[0]);
    chk({"b_valid_", ed}, b_ov, mv[1][HS_B-1]);
    chk({"b_data_", ed}, b_od, md[1][HS_B-1][7:0]);
    chk({"b_cnt_", ed}, b_cnt, mc[1]);
    chk({"b_perr_", ed}, b_pe, mp[1]);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 8; k++) begin
        mv[u][k] = 1'b0;
        md[u][k] = '0;
      end
      mc[u] = 0;
      mp[u] = 1'b0;
    end
  end

  always @(posedge clk) model_edge(1'b0);
  always @(negedge clk) model_edge(1'b1);

  always @(posedge clk) begin
    #2;
    if (chk_en) compare_all("pos");
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) compare_all("neg");
  end

  // words leaving A while en is high during the hold scenario
  bit         hold_win = 1'b0;
  logic [7:0] hold_q[$];

  always @(negedge clk) begin
    bit en_n;
    en_n = en;
    #2;
    if (hold_win && en_n && a_ov) hold_q.push_back(a_od);
  end

  initial begin
    logic [15:0] ca0;
    logic [3:0]  cb;
    logic [7:0]  db;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_a_valid", a_ov, 0);
    chk("rst_a_data", a_od, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_perr", a_pe, 0);
    chk("rst_b_valid", b_ov, 0);
    chk("rst_b_cnt", b_cnt, 0);

    // latency: A loads stage 1 on the following negedge
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_early", a_ov, 0);
    @(negedge clk); #2;
    chk("lat_data", a_od, 8'hA5);
    chk("lat_valid", a_ov, 1);
    chk("lat_cnt", a_cnt, 1);

    // hold: 1,2,3 with en low for three cycles
    @(posedge clk); #1;
    ca0 = a_cnt;
    hold_win = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd1;
    @(posedge clk); #1 in_data = 8'd2;
    @(posedge clk); #1;
    en      = 1'b0;
    in_data = 8'd3;
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 hold_win = 1'b0;
    chk("hold_n", hold_q.size(), 3);
    for (int i = 0; i < hold_q.size() && i < 3; i++)
      chk("hold_word", hold_q[i], i + 1);
    chk("hold_cnt", a_cnt - ca0, 3);

    // flush on B with all four stages occupied
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(i);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("flush_pre", b_ov, 1);
    cb = b_cnt;
    db = b_od;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_v1", b_ov, 0);
    chk("flush_cnt", b_cnt, cb);
    chk("flush_data", b_od, db);
    @(posedge clk); #2;
    chk("flush_v2", b_ov, 0);
    chk("flush_cnt2", b_cnt, cb);

    // saturation: B has a 4-bit counter
    @(posedge clk); #1;
    ca0 = a_cnt;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_b", b_cnt, 4'hF);
    chk("sat_a", a_cnt - ca0, 20);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("sat_hold", b_cnt, 4'hF);

`ifdef HALF_CYCLE_PIPE_PARITY_EN
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    par_inj  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    par_inj  = 1'b0;
    chk("par_early", a_pe, 0);
    @(negedge clk); #2;
    chk("par_set", a_pe, 1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("par_flush", a_pe, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("par_rst", a_pe, 0);
`endif

    // random traffic, checked each half cycle against the model
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
      en       = ($urandom_range(0, 7) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_data  = 8'($urandom);
      par_inj  = ($urandom_range(0, 31) == 0);
    end
    @(posedge clk); #1;
    en       = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    par_inj  = 1'b0;
    repeat (4) @(posedge clk);
    #3 chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
